// File: rtl/frame_pkg.sv
// Frame geometry constants and writer state encoding shared with the image controller.
// Pure declarations: no latency, no backpressure.
package frame_pkg;

    localparam int FRAME_W     = 16;
    localparam int FRAME_H     = 16;
    localparam int FRAME_PIX_W = 8;

    typedef enum logic [1:0] {
        FW_IDLE  = 2'd0,
        FW_WRITE = 2'd1,
        FW_DONE  = 2'd2
    } fw_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with sync clear > load > enable priority; at_max flags the wrap point.
// Counts on the cycle after enable; no backpressure of its own.
module wrap_counter #(
    parameter int N   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] cnt,
    output logic         at_max
);

    localparam logic [N-1:0] MAX_V = N'(MAX);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/frame_writer.sv
// Raster-order pixel sink writing beats to frame RAM at y*WIDTH+x; write issued 1 cycle after accept.
// in_ready follows mem_ready combinationally while writing; a stalled beat holds all state.
module frame_writer
    import frame_pkg::*;
#(
    parameter  int WIDTH  = FRAME_W,
    parameter  int HEIGHT = FRAME_H,
    parameter  int PIX_W  = FRAME_PIX_W,
    localparam int ADDR_W = $clog2(WIDTH * HEIGHT),
    localparam int XW     = $clog2(WIDTH),
    localparam int YW     = $clog2(HEIGHT)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_data,
    input  logic              in_sof,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic              busy,
    output logic              frame_done,
    output logic              sof_err
);

    fw_state_t state_q, state_d;

    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [PIX_W-1:0]  mem_wdata_q,  mem_wdata_d;
    logic              frame_done_q, frame_done_d;
    logic              sof_err_q,    sof_err_d;

    logic              x_at_max;
    logic              y_at_max;
    logic              accept;
    logic              enter;
    logic              sof_resync;
    logic              frame_end;
    logic [ADDR_W-1:0] lin_addr;

    assign in_ready   = (state_q == FW_WRITE) && mem_ready;
    // clear outranks a same-cycle beat, so the handshake is masked rather than in_ready
    assign accept     = in_valid && in_ready && !clear;
    assign enter      = start && !clear && (state_q != FW_WRITE);
    assign sof_resync = accept && in_sof && ((x != '0) || (y != '0));
    assign frame_end  = accept && !sof_resync && x_at_max && y_at_max;
    assign lin_addr   = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);

    // A misplaced SOF restarts the frame: its pixel lands at (0,0) and the next one at (1,0).
    wrap_counter #(
        .N   (XW),
        .MAX (WIDTH - 1)
    ) u_col (
        .clk      (clk),
        .nrst     (nrst),
        .en       (accept),
        .clr      (clear || enter),
        .load     (sof_resync),
        .load_val (XW'(1)),
        .cnt      (x),
        .at_max   (x_at_max)
    );

    wrap_counter #(
        .N   (YW),
        .MAX (HEIGHT - 1)
    ) u_row (
        .clk      (clk),
        .nrst     (nrst),
        .en       (accept && x_at_max),
        .clr      (clear || enter || sof_resync),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (y),
        .at_max   (y_at_max)
    );

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = FW_IDLE;
        end else begin
            case (state_q)
                FW_IDLE:  if (start)     state_d = FW_WRITE;
                FW_WRITE: if (frame_end) state_d = FW_DONE;
                FW_DONE:  if (start)     state_d = FW_WRITE;
                default:                 state_d = FW_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_we_d     = accept;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        frame_done_d = frame_end;
        sof_err_d    = sof_err_q || sof_resync;
        if (accept) begin
            mem_addr_d  = sof_resync ? '0 : lin_addr;
            mem_wdata_d = in_data;
        end
        if (clear || enter) begin
            sof_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= FW_IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;
    assign busy       = (state_q == FW_WRITE);

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer on a 4x4 frame: expected writes are queued at accept
// and compared against mem_we/mem_addr/mem_wdata/frame_done one cycle later.
module tb_frame_writer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          in_sof;
    logic          mem_ready;
    logic          mem_we;
    logic [3:0]    mem_addr;
    logic [PW-1:0] mem_wdata;
    logic [1:0]    x;
    logic [1:0]    y;
    logic          busy;
    logic          frame_done;
    logic          sof_err;

    always #5 clk = ~clk;

    frame_writer #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    typedef struct {
        int addr;
        int data;
        int done;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   mx     = 0;
    int   my     = 0;
    int   exp_sof_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Reference raster model: position of the next pixel and its expected write.
    task automatic push_exp(input logic [PW-1:0] d, input logic sof);
        exp_t e;
        e.data = int'(d);
        e.cyc  = cyc;
        if (sof && !(mx == 0 && my == 0)) begin
            e.addr      = 0;
            e.done      = 0;
            mx          = 1;
            my          = 0;
            exp_sof_err = 1;
        end else begin
            e.addr = my * W + mx;
            e.done = (mx == W - 1 && my == H - 1) ? 1 : 0;
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr",    32'(mem_addr),   e.addr);
                check("wr_data",    32'(mem_wdata),  e.data);
                check("frame_done", 32'(frame_done), e.done);
                check("latency",    cyc - e.cyc,     1);
            end
        end else begin
            check("done_without_we", 32'(frame_done), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [PW-1:0] d, input logic sof);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                push_exp(d, sof);
                ok = 1'b1;
                tick();
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start       = 1'b0;
        mx          = 0;
        my          = 0;
        exp_sof_err = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(mem_we),     0);
        check({tag, "_addr"},  32'(mem_addr),   0);
        check({tag, "_wdata"}, 32'(mem_wdata),  0);
        check({tag, "_x"},     32'(x),          0);
        check({tag, "_y"},     32'(y),          0);
        check({tag, "_busy"},  32'(busy),       0);
        check({tag, "_done"},  32'(frame_done), 0);
        check({tag, "_sof"},   32'(sof_err),    0);
        check({tag, "_rdy"},   32'(in_ready),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_data = '0; in_sof = 1'b0; mem_ready = 1'b1;
        #12;
        check_all_zero("reset");
        tick();
        nrst = 1'b1;
        tick();
        check("idle_rdy", 32'(in_ready), 0);

        // 1: back-to-back frame
        do_start();
        check("t1_busy", 32'(busy), 1);
        for (int i = 0; i < 16; i++) send_beat(8'(8'h10 + i), 1'b0);
        @(negedge clk);
        check("t1_done_busy", 32'(busy), 0);
        check("t1_done_rdy",  32'(in_ready), 0);
        check("t1_done_x",    32'(x), 0);
        check("t1_done_y",    32'(y), 0);
        tick();

        // 2: RAM stall after five beats
        do_start();
        for (int i = 0; i < 5; i++) send_beat(8'(8'h20 + i), 1'b0);
        mem_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h25;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_stall_rdy", 32'(in_ready), 0);
            if (k > 0) check("t2_stall_we", 32'(mem_we), 0);
            check("t2_stall_x", 32'(x), 1);
            check("t2_stall_y", 32'(y), 1);
            tick();
        end
        mem_ready = 1'b1;
        for (int i = 5; i < 16; i++) send_beat(8'(8'h20 + i), 1'b0);
        tick(); tick();

        // 3: sparse valid
        do_start();
        for (int i = 0; i < 16; i++) begin
            send_beat(8'(8'h30 + i), 1'b0);
            tick();
        end
        tick();

        // 4: misplaced SOF at (2,1)
        do_start();
        for (int i = 0; i < 6; i++) send_beat(8'(8'h40 + i), 1'b0);
        check("t4_sof_before", 32'(sof_err), 0);
        send_beat(8'h46, 1'b1);
        check("t4_sof_err", 32'(sof_err), 32'(exp_sof_err));
        check("t4_x", 32'(x), 1);
        check("t4_y", 32'(y), 0);
        send_beat(8'h47, 1'b0);
        check("t4_sof_hold", 32'(sof_err), 1);
        for (int i = 0; i < 14; i++) send_beat(8'(8'h50 + i), 1'b0);
        tick(); tick();
        check("t4_sof_sticky", 32'(sof_err), 1);

        // 5: clear with a beat on offer; SOF at origin is normal
        do_start();
        check("t5_sof_cleared", 32'(sof_err), 0);
        send_beat(8'h70, 1'b1);
        for (int i = 1; i < 8; i++) send_beat(8'(8'h70 + i), 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h78;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        check("t5_we",   32'(mem_we),   0);
        check("t5_busy", 32'(busy),     0);
        check("t5_x",    32'(x),        0);
        check("t5_y",    32'(y),        0);
        check("t5_rdy",  32'(in_ready), 0);
        tick();
        in_valid = 1'b0;
        do_start();
        for (int i = 0; i < 9; i++) send_beat(8'(8'h60 + i), 1'b0);

        // 6: async reset with beat 9 pending, then start+clear
        in_valid = 1'b1;
        in_data  = 8'h69;
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check_all_zero("arst");
        in_valid = 1'b0;
        tick();
        nrst = 1'b1;
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        check("t6_busy", 32'(busy),     0);
        check("t6_rdy",  32'(in_ready), 0);
        check("t6_x",    32'(x),        0);
        tick();
        check("sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
